// File: rtl/minc_trace_pkg.sv
// minc_trace_pkg
//   Shared definitions for the minc trace capture block.
//   state_t  : capture/dump state machine encoding
//   entry_w  : width of one buffer entry {pc, top, sp}
package minc_trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DUMP  = 2'd3
    } state_t;

    function automatic int entry_w(input int pc_w, input int data_w, input int sp_w);
        return pc_w + data_w + sp_w;
    endfunction

endpackage

// File: rtl/minc_trace_if.sv
// minc_trace_if
//   Read-out stream of the trace buffer (valid/ready, oldest entry first).
//   rd_valid : entry on rd_data is valid
//   rd_ready : consumer accepts the entry
//   rd_data  : {pc, top, sp}, pc in the MSBs
//   rd_last  : current entry is the final one of the window
//   master modport = trace block, slave modport = consumer
interface minc_trace_if
    import minc_trace_pkg::*;
#(
    parameter int W = entry_w(8, 8, 8)
);
    logic         rd_valid;
    logic         rd_ready;
    logic [W-1:0] rd_data;
    logic         rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/minc_trace_ram.sv
// minc_trace_ram
//   DEPTH x W register array, one synchronous write port and one
//   asynchronous read port. Contents are not reset.
//   CLK   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : mem[raddr], combinational
module minc_trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/minc_trace.sv
// minc_trace
//   Trace capture for the minc core. Every retired step stores {pc, top, sp}
//   into a circular buffer; after a PC-match or forced trigger plus
//   post_count further steps the capture stops and the window is streamed
//   out oldest-first on the rd interface.
//   CLK, nRESET       : clock, asynchronous active-low reset
//   step_valid        : core retired a step, sample pc_in/top_in/sp_in
//   arm               : clear buffer and start capturing
//   trig_en, trig_pc  : PC-match trigger
//   force_trig        : unconditional trigger (held pending until a step)
//   post_count        : samples stored after the trigger sample
//   armed, triggered, wrapped, fill : status
//   rd                : read-out stream (master side)
module minc_trace
    import minc_trace_pkg::*;
#(
    parameter int PC_W   = 8,
    parameter int DATA_W = 8,
    parameter int SP_W   = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic              step_valid,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [DATA_W-1:0] top_in,
    input  logic [SP_W-1:0]   sp_in,
    input  logic              arm,
    input  logic              trig_en,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic              force_trig,
    input  logic [AW-1:0]     post_count,
    output logic              armed,
    output logic              triggered,
    output logic              wrapped,
    output logic [AW:0]       fill,
    minc_trace_if.master      rd
);
    localparam int EW = entry_w(PC_W, DATA_W, SP_W);

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   fill_q, fill_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic          triggered_q, triggered_d;
    logic          wrapped_q, wrapped_d;
    logic          pend_q, pend_d;
    logic          do_write;
    logic          finish;
    logic          hit;
    logic [EW-1:0] ram_rdata;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            remaining_q <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
            triggered_q <= triggered_d;
            wrapped_q   <= wrapped_d;
            pend_q      <= pend_d;
        end
    end

    // A force_trig that arrived without a step is remembered in pend_q.
    assign hit = step_valid && ((trig_en && (pc_in == trig_pc)) || force_trig || pend_q);

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        triggered_d = triggered_q;
        wrapped_d   = wrapped_q;
        pend_d      = pend_q;
        do_write    = 1'b0;
        finish      = 1'b0;

        if (arm) begin
            state_d     = ARMED;
            wptr_d      = '0;
            fill_d      = '0;
            triggered_d = 1'b0;
            wrapped_d   = 1'b0;
            pend_d      = 1'b0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (step_valid) begin
                        do_write = 1'b1;
                        if (hit) begin
                            // post_count is AW bits wide, so it never exceeds DEPTH-1.
                            triggered_d = 1'b1;
                            pend_d      = 1'b0;
                            remaining_d = post_count;
                            if (post_count == '0) begin
                                finish = 1'b1;
                            end else begin
                                state_d = POST;
                            end
                        end
                    end else if (force_trig) begin
                        pend_d = 1'b1;
                    end
                end
                POST: begin
                    if (step_valid) begin
                        do_write    = 1'b1;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == AW'(1)) begin
                            finish = 1'b1;
                        end
                    end
                end
                DUMP: begin
                    if (rd.rd_ready) begin
                        rptr_d = rptr_q + 1'b1;
                        cnt_d  = cnt_q - 1'b1;
                        if (cnt_q == (AW+1)'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        // Once full, fill saturates and each further write drops the oldest entry.
        if (do_write) begin
            wptr_d = wptr_q + 1'b1;
            if (fill_q == (AW+1)'(DEPTH)) begin
                wrapped_d = 1'b1;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end

        // After a wrap the oldest entry sits at the next write slot.
        if (finish) begin
            state_d = DUMP;
            rptr_d  = wrapped_d ? wptr_d : '0;
            cnt_d   = fill_d;
        end
    end

    minc_trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_ram (
        .CLK   (CLK),
        .we    (do_write),
        .waddr (wptr_q),
        .wdata ({pc_in, top_in, sp_in}),
        .raddr (rptr_q),
        .rdata (ram_rdata)
    );

    assign armed       = (state_q == ARMED);
    assign triggered   = triggered_q;
    assign wrapped     = wrapped_q;
    assign fill        = fill_q;
    assign rd.rd_valid = (state_q == DUMP);
    assign rd.rd_last  = (state_q == DUMP) && (cnt_q == (AW+1)'(1));
    assign rd.rd_data  = (state_q == DUMP) ? ram_rdata : '0;
endmodule

// File: tb/tb_minc_trace.sv
// tb_minc_trace
//   Self-checking bench for minc_trace (DEPTH = 8). A reference model keeps
//   the sample history as a queue; when a capture window closes it pushes
//   the newest DEPTH samples onto a scoreboard queue, and an independent
//   monitor pops and compares every streamed entry.
module tb_minc_trace;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int EW    = 24;

    typedef enum {M_IDLE, M_ARMED, M_POST, M_DUMP} mode_e;
    typedef struct {
        logic [EW-1:0] data;
        bit            last;
    } exp_t;

    logic          CLK;
    logic          nRESET;
    logic          step_valid;
    logic [7:0]    pc_in;
    logic [7:0]    top_in;
    logic [7:0]    sp_in;
    logic          arm;
    logic          trig_en;
    logic [7:0]    trig_pc;
    logic          force_trig;
    logic [AW-1:0] post_count;
    logic          armed;
    logic          triggered;
    logic          wrapped;
    logic [AW:0]   fill;

    minc_trace_if #(.W(EW)) rd_if ();

    minc_trace #(
        .PC_W(8), .DATA_W(8), .SP_W(8), .DEPTH(DEPTH)
    ) dut (
        .CLK(CLK), .nRESET(nRESET), .step_valid(step_valid),
        .pc_in(pc_in), .top_in(top_in), .sp_in(sp_in),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .force_trig(force_trig), .post_count(post_count),
        .armed(armed), .triggered(triggered), .wrapped(wrapped),
        .fill(fill), .rd(rd_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    mode_e         mode = M_IDLE;
    logic [EW-1:0] hist[$];
    exp_t          expQ[$];
    int            total = 0;
    bit            mTrig = 0;
    bit            mPend = 0;
    int            mRem  = 0;

    int entryIdx  = 0;
    int stallAt   = -1;
    int stallLeft = 0;
    bit holdReady = 0;
    bit randReady = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Consumer: ready high unless held, stalled on a chosen entry, or randomised.
    initial begin
        rd_if.rd_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            if (holdReady) begin
                rd_if.rd_ready = 1'b0;
            end else if (rd_if.rd_valid && stallLeft > 0 && entryIdx == stallAt) begin
                rd_if.rd_ready = 1'b0;
                stallLeft--;
            end else if (randReady) begin
                rd_if.rd_ready = ($urandom % 3) != 0;
            end else begin
                rd_if.rd_ready = 1'b1;
            end
        end
    end

    // Monitor: every valid cycle must show the oldest outstanding entry;
    // a handshake retires it.
    always @(negedge CLK) begin
        if (nRESET && rd_if.rd_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected rd_valid", 32'(rd_if.rd_valid), 32'd0);
            end else begin
                checkOutput("rd_data", 32'(rd_if.rd_data), 32'(expQ[0].data));
                checkOutput("rd_last", 32'(rd_if.rd_last), 32'(expQ[0].last));
                if (rd_if.rd_ready) begin
                    void'(expQ.pop_front());
                    entryIdx++;
                end
            end
        end
    end

    function automatic int modelFill();
        return (total < DEPTH) ? total : DEPTH;
    endfunction

    task automatic closeWindow();
        for (int i = 0; i < hist.size(); i++) begin
            expQ.push_back('{data: hist[i], last: (i == hist.size() - 1)});
        end
        mode = M_DUMP;
    endtask

    task automatic record(input logic [EW-1:0] e);
        hist.push_back(e);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        total++;
    endtask

    task automatic checkCapture();
        checkOutput("armed",     32'(armed),         32'(mode == M_ARMED));
        checkOutput("triggered", 32'(triggered),     32'(mTrig));
        checkOutput("fill",      32'(fill),          32'(modelFill()));
        checkOutput("wrapped",   32'(wrapped),       32'(total > DEPTH));
        checkOutput("rd_valid",  32'(rd_if.rd_valid), 32'(mode == M_DUMP));
    endtask

    // Drives one cycle of inputs, advances the model, then checks status.
    task automatic applyStimulus(input bit a, input bit sv, input logic [7:0] pc,
                                 input bit ten, input logic [7:0] tpc,
                                 input bit ft, input logic [AW-1:0] pcnt);
        logic [7:0] t = 8'($urandom);
        logic [7:0] s = 8'($urandom);
        arm = a; step_valid = sv; pc_in = pc; top_in = t; sp_in = s;
        trig_en = ten; trig_pc = tpc; force_trig = ft; post_count = pcnt;
        if (a) begin
            mode = M_ARMED; hist.delete(); total = 0;
            mTrig = 0; mPend = 0; entryIdx = 0;
        end else if (mode == M_ARMED) begin
            if (sv) begin
                record({pc, t, s});
                if ((ten && pc == tpc) || ft || mPend) begin
                    mTrig = 1; mPend = 0; mRem = int'(pcnt);
                    if (mRem == 0) closeWindow();
                    else mode = M_POST;
                end
            end else if (ft) begin
                mPend = 1;
            end
        end else if (mode == M_POST && sv) begin
            record({pc, t, s});
            mRem--;
            if (mRem == 0) closeWindow();
        end
        @(posedge CLK);
        #1;
        checkCapture();
    endtask

    task automatic runCapture(input bit ten, input logic [7:0] tpc, input logic [AW-1:0] pcnt,
                              input bit gaps, input bit rndPc, input bit rndForce);
        logic [7:0] pc = 8'd0;
        applyStimulus(1, 0, 8'd0, ten, tpc, 0, pcnt);
        for (int c = 0; c < 400 && mode != M_DUMP; c++) begin
            bit         sv = gaps ? (($urandom % 3) != 0) : 1'b1;
            bit         ft = rndForce && (($urandom % 20) == 0);
            logic [7:0] p  = rndPc ? 8'($urandom % 16) : pc;
            applyStimulus(0, sv, p, ten, tpc, ft, pcnt);
            if (sv) pc++;
        end
        checkOutput("capture done", 32'(rd_if.rd_valid), 32'd1);
    endtask

    // Lets the stream drain while feeding steps the DUT must ignore.
    task automatic waitDump();
        for (int c = 0; c < 300 && !(expQ.size() == 0 && !rd_if.rd_valid); c++) begin
            arm = 0; force_trig = 0; trig_en = 0;
            step_valid = $urandom % 2; pc_in = 8'($urandom);
            @(posedge CLK);
            #1;
        end
        checkOutput("dump drained", 32'(expQ.size()), 32'd0);
        expQ.delete();
        mode = M_IDLE;
        checkOutput("post-dump rd_valid",  32'(rd_if.rd_valid), 32'd0);
        checkOutput("post-dump armed",     32'(armed),          32'd0);
        checkOutput("post-dump triggered", 32'(triggered),      32'(mTrig));
        checkOutput("post-dump fill",      32'(fill),           32'(modelFill()));
        checkOutput("post-dump wrapped",   32'(wrapped),        32'(total > DEPTH));
    endtask

    initial begin
        nRESET = 1'b0; arm = 0; step_valid = 0; pc_in = 0; top_in = 0; sp_in = 0;
        trig_en = 0; trig_pc = 0; force_trig = 0; post_count = 0;
        #22 nRESET = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("reset armed",     32'(armed),          32'd0);
        checkOutput("reset triggered", 32'(triggered),      32'd0);
        checkOutput("reset wrapped",   32'(wrapped),        32'd0);
        checkOutput("reset fill",      32'(fill),           32'd0);
        checkOutput("reset rd_valid",  32'(rd_if.rd_valid), 32'd0);
        checkOutput("reset rd_last",   32'(rd_if.rd_last),  32'd0);
        checkOutput("reset rd_data",   32'(rd_if.rd_data),  32'd0);

        $display("[TB] basic trigger");
        runCapture(1, 8'd3, 3'd2, 0, 0, 0);
        waitDump();

        $display("[TB] wrap");
        runCapture(1, 8'd20, 3'd3, 0, 0, 0);
        waitDump();

        $display("[TB] backpressure and gaps");
        stallAt = 2; stallLeft = 3;
        runCapture(1, 8'd6, 3'd3, 1, 0, 0);
        waitDump();
        stallAt = -1; stallLeft = 0;

        $display("[TB] force_trig with post_count 0");
        applyStimulus(1, 0, 8'd0, 0, 8'd0, 0, 3'd0);
        applyStimulus(0, 1, 8'd6, 0, 8'd0, 0, 3'd0);
        applyStimulus(0, 1, 8'd7, 0, 8'd0, 0, 3'd0);
        applyStimulus(0, 1, 8'd8, 0, 8'd0, 0, 3'd0);
        applyStimulus(0, 0, 8'd0, 0, 8'd0, 1, 3'd0);
        applyStimulus(0, 0, 8'd0, 0, 8'd0, 0, 3'd0);
        applyStimulus(0, 1, 8'd9, 0, 8'd0, 0, 3'd0);
        waitDump();

        $display("[TB] re-arm during POST");
        applyStimulus(1, 0, 8'd0, 1, 8'd2, 0, 3'd5);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 8'(i), 1, 8'd2, 0, 3'd5);
        applyStimulus(1, 0, 8'd0, 1, 8'd12, 0, 3'd1);
        for (int i = 10; i < 14; i++) applyStimulus(0, 1, 8'(i), 1, 8'd12, 0, 3'd1);
        waitDump();

        $display("[TB] random captures");
        randReady = 1;
        for (int r = 0; r < 4; r++) begin
            runCapture(1, 8'($urandom % 16), AW'($urandom), 1, 1, 1);
            waitDump();
        end
        randReady = 0;

        $display("[TB] reset mid-dump");
        holdReady = 1;
        runCapture(1, 8'd12, 3'd2, 0, 0, 0);
        arm = 0; step_valid = 0; force_trig = 0;
        #3 nRESET = 1'b0;
        #1;
        checkOutput("async reset rd_valid",  32'(rd_if.rd_valid), 32'd0);
        checkOutput("async reset fill",      32'(fill),           32'd0);
        checkOutput("async reset triggered", 32'(triggered),      32'd0);
        checkOutput("async reset wrapped",   32'(wrapped),        32'd0);
        expQ.delete();
        mode = M_IDLE; total = 0; mTrig = 0; hist.delete();
        holdReady = 0;
        @(negedge CLK);
        #2 nRESET = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("after reset armed",    32'(armed),          32'd0);
        checkOutput("after reset rd_valid", 32'(rd_if.rd_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
